store_align_buffer: RTL
=======================

Name: store_align_buffer

Overview:
Parametrised store-path unit between the core's memory stage and the data memory/IO write port. It decodes funct3 and the low address bits into byte-lane-aligned write data and byte enables. Stores that cross a word boundary are optionally split into two aligned beats. Beats queue in a DEPTH-entry FIFO drained over a valid/ready port, so memory stalls no longer stall store issue until the buffer fills.

Parameters:
XLEN, 32, data width; 32 or 64; NB = XLEN/8 byte lanes
ADDR_W, 32, address width
DEPTH, 4, FIFO entries; power of 2, >= 2
SPLIT_MISALIGNED, 1, 1 = split boundary-crossing stores into two beats; 0 = drop all misaligned stores and flag an error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
st_valid  in  1  store request valid
st_ready  out  1  store request accepted when st_valid && st_ready
st_funct3  in  3  000 sb, 001 sh, 010 sw, 011 sd (sd only when XLEN=64)
st_addr  in  ADDR_W  byte address
st_data  in  XLEN  rs2 value; the low size bytes are used
st_err  out  1  one-cycle registered pulse on a dropped store
mem_valid  out  1  FIFO head valid
mem_ready  in  1  memory accepts head
mem_addr  out  ADDR_W  NB-aligned beat address (low log2(NB) bits zero)
mem_data  out  XLEN  lane-aligned write data
mem_we  out  NB  byte write enables, never zero when mem_valid
buf_empty  out  1  FIFO empty and FSM IDLE; used for fence/drain
buf_count  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, rst_n low): FIFO pointers and count = 0, FSM IDLE, st_err = 0, mem_valid = 0, buf_empty = 1, buf_count = 0. mem_addr, mem_data and mem_we read 0 while the FIFO is empty. A pending second beat is discarded.
- Size sz = 1 << funct3[1:0]. off = st_addr[log2(NB)-1:0].
- An illegal funct3 is bit2 set, or 011 with XLEN=32. It completes the handshake, is dropped and pulses st_err.
- Lane math over a 2*NB-lane window:
  - mask = ((1<<sz)-1) << off
  - wide = (st_data truncated to sz bytes, zero-extended) << 8*off
  - beat0 = {addr & ~(NB-1), wide[XLEN-1:0], mask[NB-1:0]}
  - beat1 = {that aligned address + NB (wraps mod 2^ADDR_W), wide[2XLEN-1:XLEN], mask[2NB-1:NB]}
- Misaligned means off mod sz != 0. Crossing means off + sz > NB.
- SPLIT_MISALIGNED=1:
  - A non-crossing store (aligned or not) pushes beat0 only.
  - A crossing store pushes beat0 on accept, latches beat1 and enters SECOND.
- SPLIT_MISALIGNED=0: a misaligned store is accepted, dropped and pulses st_err the cycle after the accept. A non-misaligned store pushes beat0.
- FSM:
  - IDLE: st_ready = !full.
  - SECOND: st_ready = 0. Push beat1 when !full, then return to IDLE. Holds indefinitely while full.
- FIFO:
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - st_ready uses pre-pop fullness, so there is no fall-through. Minimum latency is accept at cycle N -> mem_valid at N+1.
  - Pop when mem_valid && mem_ready. Head fields stay stable while mem_valid && !mem_ready.
  - Beats leave in strict push order. Pointers wrap mod DEPTH.
- st_valid with st_ready low: no state change; the request must be held by the source.

Test Plan:
1. XLEN=32, sw 0x100 data 0xDEADBEEF, mem_ready=1 -> next cycle one beat: addr 0x100, we 1111, data 0xDEADBEEF; then buf_empty=1.
2. sb 0x103 data 0x123456AB; sh 0x102 data 0xCAFE -> beats (0x100, 1000, 0xAB000000) then (0x100, 1100, 0xCAFE0000).
3. SPLIT=1, sw 0x102 data 0x11223344:
   - beat0 (0x100, 1100, 0x33440000), then beat1 (0x104, 0011, 0x00001122).
   - st_ready is low for exactly one cycle.
   - Same store at 0xFFFFFFFE: beat1 addr wraps to 0x00000000.
4. SPLIT=0, the same sw 0x102 -> no beat, st_err high for one cycle, buf_count stays 0. funct3=011 with XLEN=32 also -> st_err.
5. DEPTH=4, mem_ready=0, issue 5 sb stores:
   - After 4 accepts buf_count=4 and st_ready=0.
   - Raise mem_ready: beats drain in order.
   - A push and pop in the same cycle keep count constant.
   - A crossing store with 3 entries full stalls in SECOND until a pop.
6. Assert rst_n low asynchronously while in SECOND with 2 entries queued -> all outputs reset immediately and beat1 never appears. XLEN=64 sd 0x8 data 0x0102030405060708 -> one beat, we 0xFF.

Source files
------------

// File: rtl/store_align_buffer_if.sv
// Store-request and memory-write bundle between the core, the store align buffer and the memory port.
interface store_align_buffer_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int NB    = XLEN / 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic              st_ready;
    logic [2:0]        st_funct3;
    logic [ADDR_W-1:0] st_addr;
    logic [XLEN-1:0]   st_data;
    logic              st_err;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_data;
    logic [NB-1:0]     mem_we;
    logic              buf_empty;
    logic [CNT_W-1:0]  buf_count;

    modport master (
        output st_valid, st_funct3, st_addr, st_data, mem_ready,
        input  st_ready, st_err, mem_valid, mem_addr, mem_data, mem_we, buf_empty, buf_count
    );

    modport slave (
        input  st_valid, st_funct3, st_addr, st_data, mem_ready,
        output st_ready, st_err, mem_valid, mem_addr, mem_data, mem_we, buf_empty, buf_count
    );
endinterface

// File: rtl/store_align_buffer.sv
// Store path: lane-aligns sb/sh/sw/sd, optionally splits word-crossing stores into two beats,
// and queues beats in a DEPTH-entry FIFO drained over a valid/ready memory port.
module store_align_buffer #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter int DEPTH            = 4,
    parameter int SPLIT_MISALIGNED = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    store_align_buffer_if.slave bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {S_IDLE, S_SECOND} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] b1_addr_q;
    logic [XLEN-1:0]   b1_data_q;
    logic [NB-1:0]     b1_we_q;
    logic              err_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [XLEN-1:0]   fifo_data_q [DEPTH];
    logic [NB-1:0]     fifo_we_q   [DEPTH];

    logic [3:0]        sz_s;
    logic [OFF_W-1:0]  off_s;
    logic [4:0]        off_ext_s;
    logic              illegal_s, cross_s, misal_s;
    logic [2*NB-1:0]   size_mask_s, mask_s;
    logic [XLEN-1:0]   trunc_s;
    logic [2*XLEN-1:0] wide_s;
    logic [ADDR_W-1:0] base_addr_s;

    // Decode size/offset and build the two-word lane window for the incoming store.
    always_comb begin
        case (bus.st_funct3[1:0])
            2'b00:   sz_s = 4'd1;
            2'b01:   sz_s = 4'd2;
            2'b10:   sz_s = 4'd4;
            2'b11:   sz_s = 4'd8;
            default: sz_s = 4'd1;
        endcase
        illegal_s   = bus.st_funct3[2] || ((bus.st_funct3[1:0] == 2'b11) && (XLEN == 32));
        off_s       = bus.st_addr[OFF_W-1:0];
        off_ext_s   = 5'(off_s);
        cross_s     = (off_ext_s + 5'(sz_s)) > 5'(NB);
        misal_s     = (off_ext_s & (5'(sz_s) - 5'd1)) != 5'd0;
        size_mask_s = '0;
        trunc_s     = '0;
        for (int i = 0; i < 2*NB; i++) begin
            size_mask_s[i] = (i < int'(sz_s));
        end
        for (int i = 0; i < NB; i++) begin
            trunc_s[8*i +: 8] = (i < int'(sz_s)) ? bus.st_data[8*i +: 8] : 8'h00;
        end
        mask_s      = size_mask_s << off_s;
        wide_s      = {{XLEN{1'b0}}, trunc_s} << {off_s, 3'b000};
        base_addr_s = bus.st_addr & ~ADDR_W'(NB - 1);
    end

    logic              full_s, st_ready_s, accept_s, drop_s, split_s, push_s, pop_s;
    logic [ADDR_W-1:0] push_addr_s;
    logic [XLEN-1:0]   push_data_s;
    logic [NB-1:0]     push_we_s;

    // Handshake control; fullness is taken before any pop so an entry never falls through.
    always_comb begin
        full_s     = (count_q == CNT_W'(DEPTH));
        st_ready_s = (state_q == S_IDLE) && !full_s;
        accept_s   = bus.st_valid && st_ready_s;
        drop_s     = illegal_s || (misal_s && (SPLIT_MISALIGNED == 0));
        split_s    = cross_s && (SPLIT_MISALIGNED != 0);
        pop_s      = (count_q != '0) && bus.mem_ready;
        if (state_q == S_SECOND) begin
            push_s      = !full_s;
            push_addr_s = b1_addr_q;
            push_data_s = b1_data_q;
            push_we_s   = b1_we_q;
        end else begin
            push_s      = accept_s && !drop_s;
            push_addr_s = base_addr_s;
            push_data_s = wide_s[XLEN-1:0];
            push_we_s   = mask_s[NB-1:0];
        end
    end

    // Split FSM, second-beat latch and the dropped-store error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            b1_addr_q <= '0;
            b1_data_q <= '0;
            b1_we_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= accept_s && drop_s;
            case (state_q)
                S_IDLE: begin
                    if (accept_s && !drop_s && split_s) begin
                        state_q   <= S_SECOND;
                        b1_addr_q <= base_addr_s + ADDR_W'(NB);
                        b1_data_q <= wide_s[2*XLEN-1:XLEN];
                        b1_we_q   <= mask_s[2*NB-1:NB];
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SECOND: state_q <= full_s ? S_SECOND : S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are only observed through the valid-gated head below.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_q[wr_ptr_q] <= push_addr_s;
            fifo_data_q[wr_ptr_q] <= push_data_s;
            fifo_we_q[wr_ptr_q]   <= push_we_s;
        end
    end

    assign bus.st_ready  = st_ready_s;
    assign bus.st_err    = err_q;
    assign bus.mem_valid = (count_q != '0);
    assign bus.mem_addr  = (count_q != '0) ? fifo_addr_q[rd_ptr_q] : '0;
    assign bus.mem_data  = (count_q != '0) ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.mem_we    = (count_q != '0) ? fifo_we_q[rd_ptr_q]   : '0;
    assign bus.buf_empty = (count_q == '0) && (state_q == S_IDLE);
    assign bus.buf_count = count_q;
endmodule
